// File: rtl/pipe_mem_arbiter_if.sv
// Bus bundle between the pipeline's IF/MEM stages, the shared memory and the arbiter.
// The arbiter uses the slave view; the pipeline/memory side uses the master view.
interface pipe_mem_arbiter_if #(
  parameter int unsigned AW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          stall;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and the
// MEM stage (data has priority), sequences the wait states and returns a one-cycle ack.
module pipe_mem_arbiter #(
  parameter int unsigned WAIT = 2,
  parameter int unsigned AW   = 32
) (
  input  logic                    clock,
  input  logic                    resetn,
  pipe_mem_arbiter_if.slave       bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

  state_t        state_r, state_s;
  logic          gnt_r, gnt_s;
  logic [3:0]    cnt_r, cnt_s;
  logic [AW-1:0] addr_r, addr_s;
  logic          we_r, we_s;
  logic [31:0]   wdata_r, wdata_s;
  logic          done_s;
  logic [31:0]   i_rdata_r, d_rdata_r;
  logic          i_ack_r, d_ack_r;
  logic          mem_en_r, mem_we_r;

  // Next-state, grant and access-latch selection.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    we_s    = we_r;
    wdata_s = wdata_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.d_req) begin
          gnt_s   = 1'b1;
          addr_s  = bus.d_addr;
          we_s    = bus.d_we;
          wdata_s = bus.d_wdata;
          cnt_s   = CNT_LOAD;
          state_s = ST_ACC;
        end else if (bus.i_req) begin
          gnt_s   = 1'b0;
          addr_s  = bus.i_addr;
          we_s    = 1'b0;
          cnt_s   = CNT_LOAD;
          state_s = ST_ACC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        // cnt holds at zero on the final cycle so it can never wrap.
        if (cnt_r == 4'd0) begin
          done_s  = 1'b1;
          state_s = ST_RESP;
        end else begin
          cnt_s   = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, latches and registered outputs; mem strobes track the upcoming ACC state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      gnt_r     <= 1'b0;
      cnt_r     <= 4'd0;
      addr_r    <= '0;
      we_r      <= 1'b0;
      wdata_r   <= 32'd0;
      i_rdata_r <= 32'd0;
      d_rdata_r <= 32'd0;
      i_ack_r   <= 1'b0;
      d_ack_r   <= 1'b0;
      mem_en_r  <= 1'b0;
      mem_we_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      gnt_r    <= gnt_s;
      cnt_r    <= cnt_s;
      addr_r   <= addr_s;
      we_r     <= we_s;
      wdata_r  <= wdata_s;
      mem_en_r <= (state_s == ST_ACC);
      mem_we_r <= (state_s == ST_ACC) & we_s;
      i_ack_r  <= done_s & ~gnt_r;
      d_ack_r  <= done_s & gnt_r;
      if (done_s & ~gnt_r) begin
        i_rdata_r <= bus.mem_rdata;
      end
      if (done_s & gnt_r & ~we_r) begin
        d_rdata_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.i_rdata   = i_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.i_ack     = i_ack_r;
  assign bus.d_ack     = d_ack_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.stall     = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: a WAIT=2 instance for most scenarios and a
// WAIT=1 instance for the single-wait-state boundary; memory is a combinational model.
module tb_pipe_mem_arbiter;

  logic clock;
  logic resetn;
  int   checks;
  int   errors;

  pipe_mem_arbiter_if #(.AW(32)) b2 ();
  pipe_mem_arbiter_if #(.AW(32)) b1 ();

  pipe_mem_arbiter #(.WAIT(2), .AW(32)) dut2 (.clock(clock), .resetn(resetn), .bus(b2));
  pipe_mem_arbiter #(.WAIT(1), .AW(32)) dut1 (.clock(clock), .resetn(resetn), .bus(b1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: 0x40 holds a fixed instruction word, other words are addr ^ 0xA5A50000.
  always_comb begin
    b2.mem_rdata = (b2.mem_addr == 32'h0000_0040) ? 32'h2002_0005 : (b2.mem_addr ^ 32'hA5A5_0000);
    b1.mem_rdata = (b1.mem_addr == 32'h0000_0040) ? 32'h2002_0005 : (b1.mem_addr ^ 32'hA5A5_0000);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    b2.i_req = 1'b0; b2.i_addr = 32'd0; b2.d_req = 1'b0; b2.d_we = 1'b0;
    b2.d_addr = 32'd0; b2.d_wdata = 32'd0;
    b1.i_req = 1'b0; b1.i_addr = 32'd0; b1.d_req = 1'b0; b1.d_we = 1'b0;
    b1.d_addr = 32'd0; b1.d_wdata = 32'd0;
    step();
    step();
    chk("rst_mem_en", {31'd0, b2.mem_en}, 32'd0);
    chk("rst_i_ack", {31'd0, b2.i_ack}, 32'd0);
    chk("rst_i_rdata", b2.i_rdata, 32'd0);
    chk("rst_mem_addr", b2.mem_addr, 32'd0);
    resetn = 1'b1;
    step();

    // Single fetch from 0x40.
    b2.i_req = 1'b1; b2.i_addr = 32'h40; #1;
    chk("f_c0_stall", {31'd0, b2.stall}, 32'd1);
    chk("f_c0_mem_en", {31'd0, b2.mem_en}, 32'd0);
    step();
    chk("f_c1_mem_en", {31'd0, b2.mem_en}, 32'd1);
    chk("f_c1_mem_addr", b2.mem_addr, 32'h40);
    chk("f_c1_mem_we", {31'd0, b2.mem_we}, 32'd0);
    chk("f_c1_stall", {31'd0, b2.stall}, 32'd1);
    step();
    chk("f_c2_mem_en", {31'd0, b2.mem_en}, 32'd1);
    chk("f_c2_i_ack", {31'd0, b2.i_ack}, 32'd0);
    chk("f_c2_stall", {31'd0, b2.stall}, 32'd1);
    step();
    chk("f_c3_i_ack", {31'd0, b2.i_ack}, 32'd1);
    chk("f_c3_i_rdata", b2.i_rdata, 32'h2002_0005);
    chk("f_c3_stall", {31'd0, b2.stall}, 32'd0);
    chk("f_c3_mem_en", {31'd0, b2.mem_en}, 32'd0);
    b2.i_req = 1'b0;
    step();
    chk("f_c4_i_ack", {31'd0, b2.i_ack}, 32'd0);

    // Conflict: load from 0x84 and fetch from 0x100 in the same cycle.
    b2.i_req = 1'b1; b2.i_addr = 32'h100;
    b2.d_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = 32'h84; #1;
    chk("c_c0_stall", {31'd0, b2.stall}, 32'd1);
    step();
    chk("c_c1_mem_addr", b2.mem_addr, 32'h84);
    chk("c_c1_stall", {31'd0, b2.stall}, 32'd1);
    step();
    chk("c_c2_stall", {31'd0, b2.stall}, 32'd1);
    step();
    chk("c_c3_d_ack", {31'd0, b2.d_ack}, 32'd1);
    chk("c_c3_d_rdata", b2.d_rdata, 32'hA5A5_0084);
    chk("c_c3_i_ack", {31'd0, b2.i_ack}, 32'd0);
    chk("c_c3_stall", {31'd0, b2.stall}, 32'd1);
    b2.d_req = 1'b0;
    step();
    chk("c_c4_mem_en", {31'd0, b2.mem_en}, 32'd0);
    chk("c_c4_stall", {31'd0, b2.stall}, 32'd1);
    step();
    chk("c_c5_mem_addr", b2.mem_addr, 32'h100);
    chk("c_c5_mem_en", {31'd0, b2.mem_en}, 32'd1);
    chk("c_c5_stall", {31'd0, b2.stall}, 32'd1);
    step();
    chk("c_c6_stall", {31'd0, b2.stall}, 32'd1);
    chk("c_c6_i_ack", {31'd0, b2.i_ack}, 32'd0);
    step();
    chk("c_c7_i_ack", {31'd0, b2.i_ack}, 32'd1);
    chk("c_c7_i_rdata", b2.i_rdata, 32'hA5A5_0100);
    chk("c_c7_d_rdata_hold", b2.d_rdata, 32'hA5A5_0084);
    chk("c_c7_stall", {31'd0, b2.stall}, 32'd0);
    b2.i_req = 1'b0;
    step();

    // Back-to-back fetches 0x0 then 0x4 with i_req held across the ack.
    b2.i_req = 1'b1; b2.i_addr = 32'h0;
    step();
    step();
    step();
    chk("b_c3_i_ack", {31'd0, b2.i_ack}, 32'd1);
    chk("b_c3_i_rdata", b2.i_rdata, 32'hA5A5_0000);
    b2.i_addr = 32'h4;
    step();
    chk("b_c4_i_ack", {31'd0, b2.i_ack}, 32'd0);
    chk("b_c4_mem_en", {31'd0, b2.mem_en}, 32'd0);
    step();
    chk("b_c5_mem_en", {31'd0, b2.mem_en}, 32'd1);
    chk("b_c5_mem_addr", b2.mem_addr, 32'h4);
    step();
    chk("b_c6_i_ack", {31'd0, b2.i_ack}, 32'd0);
    step();
    chk("b_c7_i_ack", {31'd0, b2.i_ack}, 32'd1);
    chk("b_c7_i_rdata", b2.i_rdata, 32'hA5A5_0004);
    b2.i_req = 1'b0;
    step();

    // Store 0xDEADBEEF to 0x80; d_rdata must keep the earlier load value.
    b2.d_req = 1'b1; b2.d_we = 1'b1; b2.d_addr = 32'h80; b2.d_wdata = 32'hDEAD_BEEF; #1;
    chk("s_c0_mem_we", {31'd0, b2.mem_we}, 32'd0);
    step();
    chk("s_c1_mem_we", {31'd0, b2.mem_we}, 32'd1);
    chk("s_c1_mem_wdata", b2.mem_wdata, 32'hDEAD_BEEF);
    chk("s_c1_mem_addr", b2.mem_addr, 32'h80);
    step();
    chk("s_c2_mem_we", {31'd0, b2.mem_we}, 32'd1);
    step();
    chk("s_c3_d_ack", {31'd0, b2.d_ack}, 32'd1);
    chk("s_c3_mem_we", {31'd0, b2.mem_we}, 32'd0);
    chk("s_c3_d_rdata", b2.d_rdata, 32'hA5A5_0084);
    b2.d_req = 1'b0; b2.d_we = 1'b0;
    step();
    chk("s_c4_d_ack", {31'd0, b2.d_ack}, 32'd0);

    // WAIT=1: load from 0x88 with d_req dropped during the single ACC cycle.
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h88;
    step();
    chk("w1_c1_mem_en", {31'd0, b1.mem_en}, 32'd1);
    chk("w1_c1_mem_addr", b1.mem_addr, 32'h88);
    b1.d_req = 1'b0; #1;
    chk("w1_c1_stall", {31'd0, b1.stall}, 32'd0);
    step();
    chk("w1_c2_d_ack", {31'd0, b1.d_ack}, 32'd1);
    chk("w1_c2_d_rdata", b1.d_rdata, 32'hA5A5_0088);
    chk("w1_c2_mem_en", {31'd0, b1.mem_en}, 32'd0);
    step();
    chk("w1_c3_d_ack", {31'd0, b1.d_ack}, 32'd0);
    step();
    chk("w1_c4_mem_en", {31'd0, b1.mem_en}, 32'd0);
    step();
    chk("w1_c5_mem_en", {31'd0, b1.mem_en}, 32'd0);

    // Reset in the middle of a store on the WAIT=2 instance.
    b2.d_req = 1'b1; b2.d_we = 1'b1; b2.d_addr = 32'hC0; b2.d_wdata = 32'h1234_5678;
    step();
    chk("r_c1_mem_we", {31'd0, b2.mem_we}, 32'd1);
    resetn = 1'b0; #1;
    chk("r_mem_we", {31'd0, b2.mem_we}, 32'd0);
    chk("r_mem_en", {31'd0, b2.mem_en}, 32'd0);
    chk("r_mem_addr", b2.mem_addr, 32'd0);
    chk("r_mem_wdata", b2.mem_wdata, 32'd0);
    chk("r_i_rdata", b2.i_rdata, 32'd0);
    chk("r_d_rdata", b2.d_rdata, 32'd0);
    chk("r_d_ack", {31'd0, b2.d_ack}, 32'd0);
    chk("r_stall_req", {31'd0, b2.stall}, 32'd1);
    b2.d_req = 1'b0; b2.d_we = 1'b0; #1;
    chk("r_stall_noreq", {31'd0, b2.stall}, 32'd0);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r_idle_mem_en", {31'd0, b2.mem_en}, 32'd0);
      chk("r_idle_d_ack", {31'd0, b2.d_ack}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
